bloom_lookup_sched: RTL and testbench
=====================================

# bloom_lookup_sched

Scheduler for the firewall Bloom-filter datapath. It arbitrates the single multi-cycle hash engine and the single-port bit-array BRAM between a packet-path lookup requester and a control-plane insert requester, and it sequences full bit-array clears. It sits between the packet classifier front end and the hash/bit-array pair, and returns one hit/miss result per lookup over a valid/ready handshake.

## Interface
- KEY_W, 72, key width ({src_ip, dst_ip, protocol})
- ADDR_W, 3, bit-array index width; array depth = 2^ADDR_W
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- clk  in  1  clock
- reset  in  1  async active-high reset
- lk_valid / lk_ready / lk_key  in/out/in  1/1/KEY_W  lookup request channel
- in_valid / in_ready / in_key  in/out/in  1/1/KEY_W  insert request channel
- clr_req  in  1  single-cycle pulse; request a full bit-array clear
- clr_busy  out  1  high while a clear is pending or running
- res_valid / res_ready / res_hit  out/in/out  1/1/1  lookup result channel
- hash_start  out  1  one-cycle pulse; hash_key is valid in the same cycle
- hash_key  out  KEY_W  registered key presented to the hash engine
- hash_valid  in  1  one-cycle pulse; hash_value is valid in the same cycle
- hash_value  in  32  hash result; only bits [ADDR_W-1:0] are used
- mem_addr / mem_we / mem_wdata  out  ADDR_W/1/1  BRAM port
- mem_rdata  in  1  BRAM read data; valid 1 cycle after the read address is presented

## Operation
- States: IDLE, HASH, READ, RDWAIT, RESP, WRITE, CLEAR.
- IDLE: if a clear is pending (clr_pend), go to CLEAR; both ready outputs stay low.
- IDLE arbitration, with clr_pend=0:
  - lk_ready = !in_valid || rr==LK.
  - in_ready = !lk_valid || rr==IN.
  - On a handshake, register the key and the op type, set rr to the other requester, go to HASH.
- HASH: hash_start is high for the first cycle only. Wait for hash_valid, then register idx = hash_value[ADDR_W-1:0]. Next state is READ for a lookup and WRITE for an insert.
- WRITE: mem_addr=idx, mem_we=1, mem_wdata=1 for one cycle, then IDLE.
- READ: mem_addr=idx, mem_we=0 for one cycle, then RDWAIT.
- RDWAIT: res_hit <= mem_rdata, then RESP.
- RESP: res_valid=1. res_hit is held stable until res_valid && res_ready, then IDLE.
- clr_req sets clr_pend in any state. The current operation completes first.
- CLEAR: write 0 to addresses 0..2^ADDR_W-1, one per cycle, using a wrapping counter. On the final address, clear clr_pend and go to IDLE.
- clr_busy = clr_pend || state==CLEAR.
- A clr_req that arrives during CLEAR is absorbed and does not cause a second pass.
- mem_we=0 and hash_start=0 in every state not listed above.

## Timing
- Reset values: all ready outputs 0, res_valid 0, res_hit 0, hash_start 0, mem_we 0, mem_addr 0, mem_wdata 0, clr_busy 0, rr=LK, state IDLE.
- Ready outputs depend combinationally on state, clr_pend, rr and the other requester's valid only. A requester's valid never feeds its own ready.
- Let the handshake occur at posedge T and let hash_valid be sampled at posedge T+1+L, where L ≥ 1 is the hash latency.
- Lookup: READ is cycle T+2+L; res_valid is first high in cycle T+4+L.
- Insert: mem_we is high in cycle T+2+L; in_ready can be high again in T+3+L.
- Throughput: one operation in flight at a time; no hash_start while busy.
- Clear duration: exactly 2^ADDR_W cycles with clr_busy=1, plus the wait for any operation already in flight.
- A hash_valid received outside HASH is ignored.
- Reset mid-operation returns to IDLE with the reset values above and drops clr_pend. Bit-array contents are not touched.

## Configuration
- BLOOM_SCHED_STATS_EN defined:
  - Adds output ports stat_lookups, stat_hits and stat_inserts, each 32 bits.
  - Each counter increments once per completed lookup, lookup with res_hit=1, and insert respectively.
  - Counters saturate at 0xFFFFFFFF and reset to 0. CLEAR does not change them.
- BLOOM_SCHED_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
All scenarios use ADDR_W=3 and a hash stub with L=6 that returns 0x00000005 for K1 and 0x0000000A for K2.
- Reset released, no valids -> lk_ready=1, in_ready=1, res_valid=0, clr_busy=0, mem_we=0.
- Lookup K1 on an all-zero array -> mem_addr=5 in READ; res_valid high 10 cycles after the handshake; res_hit=0.
- Insert K1, then look up K1 and K2 -> write to addr 5 with wdata=1; K1 res_hit=1; K2 (idx 2) res_hit=0.
- lk_valid and in_valid both held high from reset -> grants alternate lookup, insert, lookup, insert; never two consecutive grants to the same requester.
- Insert K1, pulse clr_req, then look up K1 -> clr_busy high 8 cycles; writes of 0 to addr 0..7 in order; K1 res_hit=0.
- Hold res_ready=0 for 5 cycles in RESP -> res_valid and res_hit stable; lk_ready=in_ready=0; assert reset mid-HASH -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/bloom_lookup_sched_if.sv
// rtl/bloom_lookup_sched_if.sv - handshake and bus bundle for the Bloom lookup scheduler
//
// Purpose: groups every non-clock signal of bloom_lookup_sched.
// Channels: lookup request (lk_*), insert request (in_*), clear request
// (clr_req/clr_busy), lookup result (res_*), hash engine (hash_*),
// bit-array BRAM port (mem_*).
// modport slave  : scheduler view
// modport master : environment view (classifier, control plane, hash, BRAM)
interface bloom_lookup_sched_if #(
  parameter int KEY_W  = 72,
  parameter int ADDR_W = 3
);
  logic              lk_valid;
  logic              lk_ready;
  logic [KEY_W-1:0]  lk_key;
  logic              in_valid;
  logic              in_ready;
  logic [KEY_W-1:0]  in_key;
  logic              clr_req;
  logic              clr_busy;
  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic              hash_start;
  logic [KEY_W-1:0]  hash_key;
  logic              hash_valid;
  logic [31:0]       hash_value;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_wdata;
  logic              mem_rdata;

  modport slave (
    input  lk_valid, lk_key, in_valid, in_key, clr_req, res_ready,
           hash_valid, hash_value, mem_rdata,
    output lk_ready, in_ready, clr_busy, res_valid, res_hit,
           hash_start, hash_key, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output lk_valid, lk_key, in_valid, in_key, clr_req, res_ready,
           hash_valid, hash_value, mem_rdata,
    input  lk_ready, in_ready, clr_busy, res_valid, res_hit,
           hash_start, hash_key, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/bloom_lookup_sched.sv
// rtl/bloom_lookup_sched.sv - arbiter/sequencer for the Bloom-filter hash engine and bit-array BRAM
//
// Purpose: round-robin arbitration between lookup and insert requesters,
// one operation in flight through the shared hash engine and single-port
// bit array, plus full-array clear sequencing.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : bloom_lookup_sched_if.slave (request, result, hash and BRAM channels)
// Optional feature: define BLOOM_SCHED_STATS_EN to add the saturating
// counters stat_lookups, stat_hits and stat_inserts (32-bit outputs).
module bloom_lookup_sched #(
  parameter int KEY_W  = 72,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  bloom_lookup_sched_if.slave bus
`ifdef BLOOM_SCHED_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_inserts
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HASH   = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_RDWAIT = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_CLEAR  = 3'd6;

  localparam logic RR_LK = 1'b0;
  localparam logic RR_IN = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [2:0]        r_state;
  logic              r_rr;
  logic              r_clr_pend;
  logic              r_is_lk;
  logic [KEY_W-1:0]  r_key;
  logic              r_first;
  logic [ADDR_W-1:0] r_idx;
  logic              r_res_hit;
  logic [ADDR_W-1:0] r_clr_cnt;

  logic w_idle_open;
  logic w_lk_hs;
  logic w_in_hs;
  logic w_res_hs;
  logic w_clr_last;

  // Ready is gated by reset so both readies read 0 while reset is held.
  // Neither ready looks at its own valid, only at the other requester's.
  assign w_idle_open  = (r_state == S_IDLE) && !r_clr_pend && !reset;
  assign bus.lk_ready = w_idle_open && (!bus.in_valid || (r_rr == RR_LK));
  assign bus.in_ready = w_idle_open && (!bus.lk_valid || (r_rr == RR_IN));

  assign w_lk_hs    = bus.lk_valid && bus.lk_ready;
  assign w_in_hs    = bus.in_valid && bus.in_ready;
  assign w_res_hs   = (r_state == S_RESP) && bus.res_ready;
  assign w_clr_last = (r_state == S_CLEAR) && (r_clr_cnt == LAST_ADDR);

  assign bus.clr_busy   = r_clr_pend || (r_state == S_CLEAR);
  assign bus.res_valid  = (r_state == S_RESP);
  assign bus.res_hit    = r_res_hit;
  assign bus.hash_start = (r_state == S_HASH) && r_first;
  assign bus.hash_key   = r_key;
  assign bus.mem_we     = (r_state == S_WRITE) || (r_state == S_CLEAR);
  assign bus.mem_wdata  = (r_state == S_WRITE);

  always_comb begin
    bus.mem_addr = '0;
    case (r_state)
      S_READ, S_WRITE: bus.mem_addr = r_idx;
      S_CLEAR:         bus.mem_addr = r_clr_cnt;
      default:         bus.mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr      <= RR_LK;
      r_is_lk   <= 1'b0;
      r_key     <= '0;
      r_first   <= 1'b0;
      r_idx     <= '0;
      r_res_hit <= 1'b0;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_lk_hs || w_in_hs) begin
            r_key   <= w_lk_hs ? bus.lk_key : bus.in_key;
            r_is_lk <= w_lk_hs;
            r_rr    <= w_lk_hs ? RR_IN : RR_LK;
            r_first <= 1'b1;
            r_state <= S_HASH;
          end else if (r_clr_pend || bus.clr_req) begin
            // A request arriving while idle starts the pass at once, so
            // clr_busy covers exactly the array depth.
            r_clr_cnt <= '0;
            r_state   <= S_CLEAR;
          end
        end
        S_HASH: begin
          r_first <= 1'b0;
          if (bus.hash_valid) begin
            r_idx   <= bus.hash_value[ADDR_W-1:0];
            r_state <= r_is_lk ? S_READ : S_WRITE;
          end
        end
        S_READ:   r_state <= S_RDWAIT;
        S_RDWAIT: begin
          r_res_hit <= bus.mem_rdata;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (bus.res_ready) r_state <= S_IDLE;
        end
        S_WRITE:  r_state <= S_IDLE;
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (w_clr_last) r_state <= S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Requests seen during CLEAR are absorbed by the pass already running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_pend <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      if (w_clr_last) r_clr_pend <= 1'b0;
    end else if (bus.clr_req) begin
      r_clr_pend <= 1'b1;
    end
  end

`ifdef BLOOM_SCHED_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_inserts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_lookups <= '0;
      r_stat_hits    <= '0;
      r_stat_inserts <= '0;
    end else begin
      if (w_res_hs && (r_stat_lookups != 32'hFFFF_FFFF))
        r_stat_lookups <= r_stat_lookups + 32'd1;
      if (w_res_hs && r_res_hit && (r_stat_hits != 32'hFFFF_FFFF))
        r_stat_hits <= r_stat_hits + 32'd1;
      if ((r_state == S_WRITE) && (r_stat_inserts != 32'hFFFF_FFFF))
        r_stat_inserts <= r_stat_inserts + 32'd1;
    end
  end

  assign stat_lookups = r_stat_lookups;
  assign stat_hits    = r_stat_hits;
  assign stat_inserts = r_stat_inserts;
`endif

endmodule

// File: tb/tb_bloom_lookup_sched.sv
// tb/tb_bloom_lookup_sched.sv - self-checking bench for bloom_lookup_sched
module tb_bloom_lookup_sched;
  localparam int KEY_W  = 72;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int HLAT   = 6;
  localparam logic [KEY_W-1:0] K1 = 72'hC0A80001_C0A80002_11;
  localparam logic [KEY_W-1:0] K2 = 72'hC0A80003_C0A80004_06;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bloom_lookup_sched_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) bus ();

`ifdef BLOOM_SCHED_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_inserts;
`endif

  bloom_lookup_sched #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BLOOM_SCHED_STATS_EN
    ,
    .stat_lookups (stat_lookups),
    .stat_hits    (stat_hits),
    .stat_inserts (stat_inserts)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] hash_of(input logic [KEY_W-1:0] k);
    if (k == K1) return 32'h0000_0005;
    if (k == K2) return 32'h0000_000A;
    return k[31:0] ^ k[63:32] ^ {24'd0, k[71:64]};
  endfunction

  // Hash engine stub: hash_valid pulses HLAT cycles after hash_start.
  logic [KEY_W-1:0] stub_key = '0;
  int stub_cnt = 0;
  always @(posedge clk) begin
    if (bus.hash_start) begin
      stub_key <= bus.hash_key;
      stub_cnt <= HLAT;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign bus.hash_valid = (stub_cnt == 1);
  assign bus.hash_value = bus.hash_valid ? hash_of(stub_key) : 32'hFFFF_FFF7;

  // Single-port bit-array BRAM with one-cycle read latency.
  logic bram [DEPTH] = '{default: 1'b0};
  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bram[bus.mem_addr];
  end

  bit model_bits [DEPTH];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Issue one request, check timing/address, and for lookups the result.
  task automatic run_op(input bit is_lk, input logic [KEY_W-1:0] key, input bit exp_hit,
                        input logic [ADDR_W-1:0] exp_idx, input int hold, input string tag);
    int t_hs;
    int e;
    bit done;
    t_hs = -1;
    done = 0;
    bus.res_ready = 1'b0;
    if (is_lk) begin bus.lk_valid = 1'b1; bus.lk_key = key; end
    else begin bus.in_valid = 1'b1; bus.in_key = key; end
    for (int c = 0; c < 40 && t_hs < 0; c++) begin
      #1;
      if ((is_lk && bus.lk_ready) || (!is_lk && bus.in_ready)) t_hs = cyc + 1;
      @(negedge clk);
    end
    bus.lk_valid = 1'b0;
    bus.in_valid = 1'b0;
    if (t_hs < 0) begin fail_timeout({tag, "_grant"}); return; end
    for (int c = 0; c < 60 && !done; c++) begin
      e = cyc + 1;
      if (e == t_hs + 2 + HLAT) begin
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_idx));
        check({tag, "_we"}, 32'(bus.mem_we), 32'(!is_lk));
        if (!is_lk) check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd1);
      end
      if (!is_lk && e == t_hs + 3 + HLAT) begin
        check({tag, "_in_ready_again"}, 32'(bus.in_ready), 32'd1);
        done = 1;
      end
      if (is_lk && bus.res_valid) begin
        check({tag, "_res_time"}, 32'(e), 32'(t_hs + 4 + HLAT));
        check({tag, "_hit"}, 32'(bus.res_hit), 32'(exp_hit));
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
          check({tag, "_hold_hit"}, 32'(bus.res_hit), 32'(exp_hit));
          check({tag, "_hold_readies"}, {30'd0, bus.lk_ready, bus.in_ready}, 32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_res_drop"}, 32'(bus.res_valid), 32'd0);
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    if (!done) fail_timeout({tag, "_complete"});
  endtask

  // Full clear; optionally pulses a second clr_req mid-pass to be absorbed.
  task automatic run_clear(input bit absorb, input string tag);
    int k;
    k = 0;
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    while (bus.clr_busy && k < 20) begin
      check({tag, "_addr"}, 32'(bus.mem_addr), 32'(k));
      check({tag, "_we0"}, {30'd0, bus.mem_we, bus.mem_wdata}, 32'd2);
      bus.clr_req = (absorb && k == 3);
      k++;
      @(negedge clk);
      bus.clr_req = 1'b0;
    end
    check({tag, "_busy_cycles"}, 32'(k), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model_bits[i] = 1'b0;
  endtask

  typedef struct {
    bit                is_lk;
    logic [KEY_W-1:0]  key;
    bit                exp_hit;
    logic [ADDR_W-1:0] exp_idx;
  } vec_t;
  vec_t vecs [4];
  int grants [$];
  logic [KEY_W-1:0] pool [6];

  initial begin
    vecs[0] = '{1'b1, K1, 1'b0, 3'd5};
    vecs[1] = '{1'b0, K1, 1'b0, 3'd5};
    vecs[2] = '{1'b1, K1, 1'b1, 3'd5};
    vecs[3] = '{1'b1, K2, 1'b0, 3'd2};

    reset = 1'b1;
    bus.lk_valid = 1'b0; bus.lk_key = '0;
    bus.in_valid = 1'b0; bus.in_key = '0;
    bus.clr_req = 1'b0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_readies", {30'd0, bus.lk_ready, bus.in_ready}, 32'd0);
    check("rst_outs", {26'd0, bus.res_valid, bus.res_hit, bus.hash_start, bus.mem_we,
                       bus.mem_wdata, bus.clr_busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_readies", {30'd0, bus.lk_ready, bus.in_ready}, 32'd3);
    check("idle_outs", {26'd0, bus.res_valid, bus.clr_busy, bus.mem_we, bus.hash_start,
                        bus.mem_wdata, 1'b0}, 32'd0);
    check("idle_addr", 32'(bus.mem_addr), 32'd0);

    for (int i = 0; i < 4; i++)
      run_op(vecs[i].is_lk, vecs[i].key, vecs[i].exp_hit, vecs[i].exp_idx, 0,
             $sformatf("vec%0d", i));

    run_clear(1'b1, "clear");
    check("clear_done_busy", 32'(bus.clr_busy), 32'd0);
    run_op(1'b1, K1, 1'b0, 3'd5, 0, "after_clear");

    // Both requesters held valid from reset: grants must alternate.
    reset = 1'b1;
    bus.lk_valid = 1'b1; bus.lk_key = K2;
    bus.in_valid = 1'b1; bus.in_key = K1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 400 && grants.size() < 4; c++) begin
      #1;
      if (bus.lk_ready) grants.push_back(0);
      else if (bus.in_ready) grants.push_back(1);
      @(negedge clk);
    end
    bus.lk_valid = 1'b0;
    bus.in_valid = 1'b0;
    check("arb_grants", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++)
      check($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    for (int c = 0; c < 100 && !bus.lk_ready; c++) @(negedge clk);
    check("arb_back_idle", 32'(bus.lk_ready), 32'd1);
    bus.res_ready = 1'b0;

    run_op(1'b1, K1, 1'b1, 3'd5, 5, "hold");

    // Reset in the middle of HASH with a clear pending.
    bus.lk_valid = 1'b1; bus.lk_key = K2;
    @(negedge clk);
    bus.lk_valid = 1'b0;
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    check("mid_busy", 32'(bus.clr_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_readies", {30'd0, bus.lk_ready, bus.in_ready}, 32'd0);
    check("mid_rst_outs", {26'd0, bus.res_valid, bus.res_hit, bus.hash_start, bus.mem_we,
                           bus.mem_wdata, bus.clr_busy}, 32'd0);
    check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_readies", {30'd0, bus.lk_ready, bus.in_ready}, 32'd3);
    repeat (10) @(negedge clk);
    check("stale_hash_ignored", {30'd0, bus.lk_ready, bus.clr_busy}, 32'd2);
    run_op(1'b1, K1, 1'b1, 3'd5, 0, "post_rst_lk");

    // Randomised traffic against the bit-set model.
    run_clear(1'b0, "rclear");
    pool[0] = K1;
    pool[1] = K2;
    for (int i = 2; i < 6; i++) pool[i] = {$urandom(), $urandom(), 8'($urandom())};
    for (int i = 0; i < 40; i++) begin
      int r;
      int sel;
      logic [ADDR_W-1:0] idx;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        run_clear(1'b0, $sformatf("r%0d_clr", i));
      end else begin
        sel = $urandom_range(0, 5);
        idx = hash_of(pool[sel])[ADDR_W-1:0];
        run_op(r < 6, pool[sel], model_bits[idx], idx, $urandom_range(0, 2),
               $sformatf("r%0d", i));
        if (r >= 6) model_bits[idx] = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
